// File: rtl/shift_pkg.sv
// Shared types and the normalization stop rule for the iterative left-normalizer.
// The stop rule here is written for the default 8-bit width.
package shift_pkg;

  localparam int NORM_W  = 8;
  localparam int NORM_CW = $clog2(NORM_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } norm_state_t;

  // Logical mode stops at a leading one; arithmetic mode stops where the top two bits differ.
  // Each mode also stops when its shift budget is exhausted.
  function automatic logic norm_stop(input logic [NORM_W-1:0]  r,
                                     input logic [NORM_CW-1:0] c,
                                     input logic               ar);
    if (ar) return (r[NORM_W-1] != r[NORM_W-2]) || (c == NORM_CW'(NORM_W - 1));
    else    return r[NORM_W-1] || (c == NORM_CW'(NORM_W));
  endfunction

endpackage

// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: shifts the accepted word left one bit per clock until
// normalized (logical or signed), then presents the word and the shift distance.
module seq_normalizer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic             ar,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [CW-1:0]    n,
  output logic             zero
);

  localparam logic [CW-1:0] CNT_LOG_MAX   = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ARITH_MAX = CW'(WIDTH - 1);

  norm_state_t      state_q, state_d;
  logic [WIDTH-1:0] reg_q;
  logic [CW-1:0]    cnt_q;
  logic             ar_q;
  logic             zero_q;
  logic             stop;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    stop    = 1'b0;
    state_d = state_q;
    if (ar_q) stop = (reg_q[WIDTH-1] != reg_q[WIDTH-2]) || (cnt_q == CNT_ARITH_MAX);
    else      stop = reg_q[WIDTH-1] || (cnt_q == CNT_LOG_MAX);
    unique case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_SHIFT;
      S_SHIFT: if (stop)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The data registers are reset as well because o/n/zero must read zero out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      reg_q  <= '0;
      cnt_q  <= '0;
      ar_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          reg_q <= d;
          ar_q  <= ar;
          cnt_q <= '0;
        end
        S_SHIFT: begin
          if (stop) begin
            zero_q <= (reg_q == '0);
          end else begin
            reg_q <= {reg_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign o         = reg_q;
  assign n         = cnt_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed and randomized checks for seq_normalizer at WIDTH=8.
module tb_seq_normalizer;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] d = '0;
  logic       ar = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] o;
  logic [3:0] n;
  logic       zero;

  int compared   = 0;
  int mismatched = 0;

  seq_normalizer #(.WIDTH(8)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .d(d), .ar(ar),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .n(n), .zero(zero)
  );

  always #5 clk = ~clk;

  // Accepts one word, measures latency, compares the result, then completes the handshake.
  task automatic do_op(input logic [7:0] din, input logic a, input logic [7:0] exp_o,
                       input logic [3:0] exp_n, input logic exp_zero, input string name);
    int lat;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; d = din; ar = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0; d = ~din; ar = ~a;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid === 1'b1) break;
    end
    compared++;
    if (lat !== int'(exp_n) + 1 || out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, lat, out_valid, exp_n + 1);
    end
    compared++;
    if (o !== exp_o || n !== exp_n || zero !== exp_zero) begin
      mismatched++;
      $display("FAIL %s result: got o=%h n=%0d zero=%b want o=%h n=%0d zero=%b",
               name, o, n, zero, exp_o, exp_n, exp_zero);
    end
    compared++;
    if (o !== 8'(din << n)) begin
      mismatched++;
      $display("FAIL %s o==d<<n: got o=%h n=%0d d=%h", name, o, n, din);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || o !== 8'h00 || n !== 4'd0 || zero !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b o=%h n=%0d zero=%b want 1 0 00 0 0",
               in_ready, out_valid, o, n, zero);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_logical();
    do_op(8'h13, 1'b0, 8'h98, 4'd3, 1'b0, "log_13");
    do_op(8'h80, 1'b0, 8'h80, 4'd0, 1'b0, "log_80");
    do_op(8'h00, 1'b0, 8'h00, 4'd8, 1'b1, "log_00");
    do_op(8'h01, 1'b0, 8'h80, 4'd7, 1'b0, "log_01");
  endtask

  task automatic test_arith();
    // 0xF3 = -13 needs three shifts (0x98 = -104); 0x05 needs four (0x50).
    do_op(8'hF3, 1'b1, 8'h98, 4'd3, 1'b0, "ar_F3");
    do_op(8'h05, 1'b1, 8'h50, 4'd4, 1'b0, "ar_05");
    do_op(8'hFF, 1'b1, 8'h80, 4'd7, 1'b0, "ar_FF");
    do_op(8'h00, 1'b1, 8'h00, 4'd7, 1'b1, "ar_00");
    do_op(8'h40, 1'b1, 8'h40, 4'd0, 1'b0, "ar_40");
    do_op(8'hBF, 1'b1, 8'hBF, 4'd0, 1'b0, "ar_BF");
  endtask

  task automatic test_backpressure();
    int waited;
    @(negedge clk);
    in_valid = 1'b1; d = 8'h13; ar = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; d = 8'hAA; ar = 1'b1;
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || o !== 8'h98 || n !== 4'd3) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b o=%h n=%0d want 1 0 98 3",
                 i, out_valid, in_ready, o, n);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_ignored_input: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; d = 8'h01; ar = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    nrst = 1'b1;
    do_op(8'h40, 1'b0, 8'h80, 4'd1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] din, r;
    logic [3:0] c;
    logic       a;
    for (int i = 0; i < 1000; i++) begin
      din = 8'($urandom);
      a   = 1'($urandom);
      r   = din;
      c   = '0;
      while (!norm_stop(r, c, a)) begin
        r = {r[6:0], 1'b0};
        c = c + 4'd1;
      end
      do_op(din, a, r, c, (r == 8'h00), "random");
    end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
